// File: rtl/macc_seq_ctrl.sv
// Sequencer for a 2-stage signed MAC: accepts a dot-product job, streams operand pairs, returns the sum.
// Define MACC_INIT_PSUM_EN to add the LOAD state that seeds each job from init_psum through the MAC external path.
module macc_seq_ctrl #(
    parameter int SIZEIN  = 16,
    parameter int SIZEOUT = 40,
    parameter int CNT_W   = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [CNT_W-1:0]   len,
    input  logic [SIZEIN-1:0]  init_psum,
    output logic               busy,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic [SIZEIN-1:0]  op_a,
    input  logic [SIZEIN-1:0]  op_b,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [SIZEOUT-1:0] res_data,
    output logic               mac_gate,
    output logic               mac_exter,
    output logic               mac_clear,
    output logic [SIZEIN-1:0]  mac_a,
    output logic [SIZEIN-1:0]  mac_b,
    output logic [SIZEIN-1:0]  mac_ext_psum,
    output logic [SIZEIN-1:0]  mac_int_psum,
    input  logic [SIZEOUT-1:0] mac_accum
);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t               state;
    logic [CNT_W-1:0]     len_q;
    logic [CNT_W-1:0]     cnt;
    logic [SIZEOUT-1:0]   psum_q;
    logic                 fire;
    logic                 last_fire;

    assign fire      = op_valid & op_ready;
    assign last_fire = fire && ((cnt + CNT_ONE) == len_q);

    // Idle slots inside RUN feed zeros rather than gating, so the pipeline keeps its product.
    assign mac_a        = fire ? op_a : '0;
    assign mac_b        = fire ? op_b : '0;
    assign mac_int_psum = psum_q[SIZEIN-1:0];
    assign res_data     = psum_q;

`ifdef MACC_INIT_PSUM_EN
    logic               mac_exter_q;
    logic [SIZEIN-1:0]  ext_psum_q;
    assign mac_exter    = mac_exter_q;
    assign mac_ext_psum = ext_psum_q;
`else
    logic unused_init;
    assign unused_init  = ^init_psum;
    assign mac_exter    = 1'b0;
    assign mac_ext_psum = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            len_q     <= '0;
            cnt       <= '0;
            psum_q    <= '0;
            busy      <= 1'b0;
            op_ready  <= 1'b0;
            res_valid <= 1'b0;
            mac_gate  <= 1'b1;
            mac_clear <= 1'b0;
`ifdef MACC_INIT_PSUM_EN
            mac_exter_q <= 1'b0;
            ext_psum_q  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q     <= len;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        mac_clear <= 1'b1;
`ifdef MACC_INIT_PSUM_EN
                        state       <= LOAD;
                        mac_exter_q <= 1'b1;
                        ext_psum_q  <= init_psum;
`else
                        state     <= RUN;
                        mac_gate  <= 1'b0;
                        op_ready  <= (len != '0);
`endif
                    end
                end
`ifdef MACC_INIT_PSUM_EN
                LOAD: begin
                    psum_q      <= mac_accum;
                    state       <= RUN;
                    mac_exter_q <= 1'b0;
                    ext_psum_q  <= '0;
                    mac_clear   <= 1'b0;
                    mac_gate    <= 1'b0;
                    op_ready    <= (len_q != '0);
                end
`endif
                RUN: begin
                    psum_q    <= mac_accum;
                    mac_clear <= 1'b0;
                    if (fire) begin
                        cnt <= cnt + CNT_ONE;
                    end
                    // Leaving on the last accepted pair lets DRAIN pick up its product one cycle later.
                    if ((cnt == len_q) || last_fire) begin
                        state    <= DRAIN;
                        op_ready <= 1'b0;
                    end
                end
                DRAIN: begin
                    psum_q    <= mac_accum;
                    state     <= DONE;
                    mac_gate  <= 1'b1;
                    res_valid <= 1'b1;
                end
                DONE: begin
                    if (res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_macc_seq_ctrl.sv
// Scoreboard bench for macc_seq_ctrl with a behavioural 2-stage MAC model on the mac_* ports.
// Follows MACC_INIT_PSUM_EN the same way as the design.
module tb_macc_seq_ctrl;

    localparam int SIZEIN  = 16;
    localparam int SIZEOUT = 40;
    localparam int CNT_W   = 10;

`ifdef MACC_INIT_PSUM_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [CNT_W-1:0]   len;
    logic [SIZEIN-1:0]  init_psum;
    logic               busy;
    logic               op_valid;
    logic               op_ready;
    logic [SIZEIN-1:0]  op_a;
    logic [SIZEIN-1:0]  op_b;
    logic               res_valid;
    logic               res_ready;
    logic [SIZEOUT-1:0] res_data;
    logic               mac_gate;
    logic               mac_exter;
    logic               mac_clear;
    logic [SIZEIN-1:0]  mac_a;
    logic [SIZEIN-1:0]  mac_b;
    logic [SIZEIN-1:0]  mac_ext_psum;
    logic [SIZEIN-1:0]  mac_int_psum;
    logic [SIZEOUT-1:0] mac_accum;

    int      checks   = 0;
    int      failures = 0;
    longint  exp_q[$];
    int      pa[$];
    int      pb[$];

    macc_seq_ctrl #(.SIZEIN(SIZEIN), .SIZEOUT(SIZEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .init_psum(init_psum),
        .busy(busy), .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .mac_gate(mac_gate), .mac_exter(mac_exter), .mac_clear(mac_clear),
        .mac_a(mac_a), .mac_b(mac_b), .mac_ext_psum(mac_ext_psum),
        .mac_int_psum(mac_int_psum), .mac_accum(mac_accum)
    );

    always #5 clk = ~clk;

    // MAC model: registered product stage, combinational accumulate against the selected psum.
    logic signed [2*SIZEIN-1:0]  prod_full;
    logic signed [SIZEOUT-1:0]   prod_q;
    logic signed [SIZEOUT-1:0]   psum_in;
    assign prod_full = $signed(mac_a) * $signed(mac_b);

    always_ff @(posedge clk) begin
        prod_q <= mac_gate ? '0 : SIZEOUT'(prod_full);
    end

    always_comb begin
        psum_in = '0;
        if (mac_exter) begin
            psum_in = SIZEOUT'($signed(mac_ext_psum));
        end else if (!mac_clear) begin
            psum_in = SIZEOUT'($signed(mac_int_psum));
        end
        mac_accum = (mac_gate ? '0 : prod_q) + psum_in;
    end

    task automatic checkOutput(input string tag, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Runs one job from pa/pb; optional stall of gap_len cycles after gap_after pairs, and hold_cycles of res_ready=0.
    task automatic applyStimulus(input int n, input int init, input int gap_after,
                                 input int gap_len, input int hold_cycles);
        int     idx = 0;
        int     gap = 0;
        int     cyc = 0;
        int     res_cyc = -1;
        int     gate_breaks = 0;
        int     ready_seen = 0;
        int     hold_left = hold_cycles;
        int     exp_lat;
        bit     gate_low = 1'b0;
        bit     done = 1'b0;
        bit     fired;
        bit     handshake;
        longint exp_sum;
        longint held;

        exp_sum = INIT_EN ? longint'(init) : 0;
        for (int i = 0; i < n; i++) exp_sum += longint'(pa[i]) * longint'(pb[i]);
        exp_q.push_back(exp_sum);
        exp_lat = ((n == 0) ? 1 : n) + 2 + (INIT_EN ? 1 : 0)
                  + ((gap_after > 0 && gap_after < n) ? gap_len : 0);

        @(negedge clk);
        start     = 1'b1;
        len       = CNT_W'(n);
        init_psum = SIZEIN'(init);
        res_ready = 1'b0;
        op_valid  = (n > 0);
        op_a      = (n > 0) ? SIZEIN'(pa[0]) : '0;
        op_b      = (n > 0) ? SIZEIN'(pb[0]) : '0;

        while (!done && cyc < 200) begin
            fired     = op_valid && op_ready;
            handshake = res_valid && res_ready;
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (fired) begin
                idx++;
                if (idx == gap_after) gap = gap_len;
            end
            if (handshake) begin
                done = 1'b1;
                res_ready = 1'b0;
                checkOutput("idle_after_ack", busy, 0);
                checkOutput("res_valid_after_ack", res_valid, 0);
            end else begin
                if (cyc == 1) begin
                    checkOutput("first_clear", mac_clear, 1);
                    checkOutput("first_exter", mac_exter, INIT_EN ? 1 : 0);
                    checkOutput("first_gate", mac_gate, INIT_EN ? 1 : 0);
                    checkOutput("first_ext_psum", longint'($signed(mac_ext_psum)), INIT_EN ? init : 0);
                end
                if (op_ready) ready_seen++;
                if (!mac_gate) gate_low = 1'b1;
                else if (gate_low && !res_valid) gate_breaks++;
                if (res_valid) begin
                    checkOutput("busy_in_done", busy, 1);
                    if (res_cyc < 0) begin
                        res_cyc = cyc;
                        held    = longint'($signed(res_data));
                        checkOutput("latency", res_cyc, exp_lat);
                    end else begin
                        checkOutput("res_hold", longint'($signed(res_data)), held);
                    end
                    if (hold_left > 0) begin
                        hold_left--;
                        res_ready = 1'b0;
                        if (hold_left == 1) start = 1'b1;
                    end else begin
                        res_ready = 1'b1;
                        checkOutput("res_data", longint'($signed(res_data)), exp_q.pop_front());
                    end
                end
                if (gap > 0) begin
                    op_valid = 1'b0;
                    gap--;
                end else if (idx < n) begin
                    op_valid = 1'b1;
                    op_a     = SIZEIN'(pa[idx]);
                    op_b     = SIZEIN'(pb[idx]);
                end else begin
                    op_valid = 1'b0;
                end
            end
        end

        checkOutput("job_done", done, 1);
        if (!done && exp_q.size() > 0) void'(exp_q.pop_back());
        checkOutput("gate_breaks", gate_breaks, 0);
        if (n == 0) checkOutput("ready_len0", ready_seen, 0);
        else        checkOutput("pairs_sent", idx, n);
        op_valid  = 1'b0;
        res_ready = 1'b0;
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = '0;
        init_psum = '0;
        op_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        res_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_op_ready", op_ready, 0);
        checkOutput("rst_res_valid", res_valid, 0);
        checkOutput("rst_res_data", longint'(res_data), 0);
        checkOutput("rst_gate", mac_gate, 1);
        checkOutput("rst_exter", mac_exter, 0);
        checkOutput("rst_clear", mac_clear, 0);
        checkOutput("rst_mac_a", longint'(mac_a), 0);
        checkOutput("rst_ext_psum", longint'(mac_ext_psum), 0);
        rst_n = 1'b1;

        pa = '{2, -4, 7};  pb = '{3, 5, -1};
        applyStimulus(3, 0, 0, 0, 0);
        applyStimulus(3, 0, 1, 2, 0);
        pa.delete();  pb.delete();
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 37, 0, 0, 0);
        pa = '{10, -5};  pb = '{-3, -5};
        applyStimulus(2, 100, 0, 0, 0);
        pa = '{2, -4, 7};  pb = '{3, 5, -1};
        applyStimulus(3, 0, 0, 0, 4);

        for (int r = 0; r < 3; r++) begin
            n = int'($urandom_range(1, 5));
            pa.delete();  pb.delete();
            for (int i = 0; i < n; i++) begin
                pa.push_back(int'($urandom_range(0, 40)) - 20);
                pb.push_back(int'($urandom_range(0, 40)) - 20);
            end
            applyStimulus(n, int'($urandom_range(0, 200)) - 100, int'($urandom_range(1, n)),
                          int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end

        // Abort a job mid-stream with reset, then confirm a fresh job starts clean.
        @(negedge clk);
        start = 1'b1;  len = 10'd3;  init_psum = 16'd55;
        op_valid = 1'b1;  op_a = 16'd2;  op_b = 16'd3;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 4 && !op_ready; k++) @(negedge clk);
        checkOutput("abort_ready", op_ready, 1);
        @(negedge clk);
        op_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_psum", longint'(res_data), 0);
        checkOutput("abort_int_psum", longint'(mac_int_psum), 0);
        checkOutput("abort_op_ready", op_ready, 0);
        checkOutput("abort_gate", mac_gate, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("abort_no_result", res_valid, 0);
        end
        pa = '{6};  pb = '{7};
        applyStimulus(1, 0, 0, 0, 0);

        checkOutput("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
